// File: rtl/instr_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage_if
//   Bundles the instruction-memory port and the IF/ID register outputs of the
//   fetch stage into a single connection.
//
//   Memory handshake (busywait protocol):
//     A request is open in every cycle where IMEM_READ=1. It completes at the
//     rising edge where IMEM_BUSYWAIT=0, and IMEM_RDATA is valid in that cycle.
//     While IMEM_BUSYWAIT=1 the requester keeps IMEM_READ and IMEM_ADDR stable.
//
//   Signals:
//     IMEM_READ      fetch stage -> memory   read request
//     IMEM_ADDR      fetch stage -> memory   word-aligned fetch address
//     IMEM_RDATA     memory -> fetch stage   instruction word
//     IMEM_BUSYWAIT  memory -> fetch stage   access not finished yet
//     IFID_PC        fetch stage -> decode   PC of the instruction in IF/ID
//     IFID_INSTR     fetch stage -> decode   instruction (NOP when not valid)
//     IFID_VALID     fetch stage -> decode   IF/ID holds a real instruction
//
//   Modports:
//     master  the fetch stage
//     slave   memory / decode side
// -----------------------------------------------------------------------------
interface instr_fetch_stage_if;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_INSTR;
    logic        IFID_VALID;

    modport master (
        output IMEM_READ,
        output IMEM_ADDR,
        input  IMEM_RDATA,
        input  IMEM_BUSYWAIT,
        output IFID_PC,
        output IFID_INSTR,
        output IFID_VALID
    );

    modport slave (
        input  IMEM_READ,
        input  IMEM_ADDR,
        output IMEM_RDATA,
        output IMEM_BUSYWAIT,
        input  IFID_PC,
        input  IFID_INSTR,
        input  IFID_VALID
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Owns the PC,
//   talks to instruction memory with the busywait protocol, holds one fetched
//   instruction aside when the hazard unit stalls, and redirects on taken
//   branches (squashing younger instructions).
//
//   Parameters:
//     RESET_PC   PC loaded on reset
//     NOP_INSTR  instruction shown on IFID_INSTR when the slot is a bubble
//
//   Ports:
//     CLK            rising-edge clock
//     RESET          synchronous, active-low reset
//     STALL          hazard unit asks IF/ID to hold its contents
//     BRANCH_TAKEN   redirect from EX
//     BRANCH_TARGET  redirect address (bits [1:0] ignored)
//     bus            memory port + IF/ID outputs (master modport)
//     DBG_STATE      current FSM state (IDLE=0, FETCH=1, HOLD=2, DRAIN=3)
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       STALL,
    input  logic                       BRANCH_TAKEN,
    input  logic [31:0]                BRANCH_TARGET,
    instr_fetch_stage_if.master        bus,
    output logic [1:0]                 DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ifid_pc, ifid_pc_n;
    logic [31:0] ifid_instr, ifid_instr_n;
    logic        ifid_valid, ifid_valid_n;
    logic [31:0] hold_pc, hold_pc_n;
    logic [31:0] hold_instr, hold_instr_n;
    logic [31:0] drain_target, drain_target_n;

    logic [31:0] branch_pc;
    logic [31:0] pc_plus4;
    logic [31:0] drain_dest;
    logic        access_done;

    assign branch_pc   = {BRANCH_TARGET[31:2], 2'b00};
    assign pc_plus4    = pc + 32'd4;
    assign access_done = !bus.IMEM_BUSYWAIT;
    // A redirect arriving while draining replaces the saved target.
    assign drain_dest  = BRANCH_TAKEN ? branch_pc : drain_target;

    // -------------------------------------------------------------------------
    // Next-state and next-register logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        ifid_pc_n      = ifid_pc;
        ifid_instr_n   = ifid_instr;
        ifid_valid_n   = ifid_valid;
        hold_pc_n      = hold_pc;
        hold_instr_n   = hold_instr;
        drain_target_n = drain_target;

        case (state)
            S_IDLE: begin
                state_n = S_FETCH;
                if (BRANCH_TAKEN) begin
                    pc_n         = branch_pc;
                    ifid_pc_n    = 32'd0;
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                end
            end

            S_FETCH: begin
                if (BRANCH_TAKEN) begin
                    // Redirect wins over stall and over a completing access.
                    ifid_pc_n    = 32'd0;
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    hold_pc_n    = 32'd0;
                    hold_instr_n = 32'd0;
                    if (!access_done) begin
                        // Memory still owns the old address; finish it first.
                        drain_target_n = branch_pc;
                        state_n        = S_DRAIN;
                    end else begin
                        pc_n = branch_pc;
                    end
                end else if (access_done) begin
                    pc_n = pc_plus4;
                    if (!STALL) begin
                        ifid_pc_n    = pc;
                        ifid_instr_n = bus.IMEM_RDATA;
                        ifid_valid_n = 1'b1;
                    end else begin
                        // Decode cannot take it yet: park it aside.
                        hold_pc_n    = pc;
                        hold_instr_n = bus.IMEM_RDATA;
                        state_n      = S_HOLD;
                    end
                end else if (!STALL) begin
                    ifid_pc_n    = 32'd0;
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                end
            end

            S_HOLD: begin
                if (BRANCH_TAKEN) begin
                    ifid_pc_n    = 32'd0;
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    hold_pc_n    = 32'd0;
                    hold_instr_n = 32'd0;
                    pc_n         = branch_pc;
                    state_n      = S_FETCH;
                end else if (!STALL) begin
                    ifid_pc_n    = hold_pc;
                    ifid_instr_n = hold_instr;
                    ifid_valid_n = 1'b1;
                    hold_pc_n    = 32'd0;
                    hold_instr_n = 32'd0;
                    state_n      = S_FETCH;
                end
            end

            S_DRAIN: begin
                // IF/ID already carries a bubble from the redirect; any new
                // redirect keeps it that way.
                if (BRANCH_TAKEN) begin
                    ifid_pc_n    = 32'd0;
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                end
                if (access_done) begin
                    // Returned data belongs to the squashed path: drop it.
                    pc_n    = drain_dest;
                    state_n = S_FETCH;
                end else begin
                    drain_target_n = drain_dest;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            ifid_pc      <= 32'd0;
            ifid_instr   <= NOP_INSTR;
            ifid_valid   <= 1'b0;
            hold_pc      <= 32'd0;
            hold_instr   <= 32'd0;
            drain_target <= 32'd0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            ifid_pc      <= ifid_pc_n;
            ifid_instr   <= ifid_instr_n;
            ifid_valid   <= ifid_valid_n;
            hold_pc      <= hold_pc_n;
            hold_instr   <= hold_instr_n;
            drain_target <= drain_target_n;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: memory request decodes from state; during DRAIN the PC has not
    // moved yet, so IMEM_ADDR stays on the outstanding address.
    // -------------------------------------------------------------------------
    assign bus.IMEM_READ  = (state == S_FETCH) || (state == S_DRAIN);
    assign bus.IMEM_ADDR  = pc;
    assign bus.IFID_PC    = ifid_pc;
    assign bus.IFID_INSTR = ifid_instr;
    assign bus.IFID_VALID = ifid_valid;
    assign DBG_STATE      = state;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//   Directed table of per-cycle stimulus and expected outputs for the fetch
//   stage, plus a second instance with a wrapping RESET_PC for the PC-overflow
//   and reset-during-access sequence.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  dbg_state;

    logic        rst2_n;
    logic [1:0]  dbg_state2;

    instr_fetch_stage_if bus ();
    instr_fetch_stage_if bus2 ();

    instr_fetch_stage u_dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .STALL         (stall),
        .BRANCH_TAKEN  (branch_taken),
        .BRANCH_TARGET (branch_target),
        .bus           (bus.master),
        .DBG_STATE     (dbg_state)
    );

    instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK           (clk),
        .RESET         (rst2_n),
        .STALL         (1'b0),
        .BRANCH_TAKEN  (1'b0),
        .BRANCH_TARGET (32'd0),
        .bus           (bus2.master),
        .DBG_STATE     (dbg_state2)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] target;
        logic        busy;
        logic [31:0] rdata;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[32];
    int   n_rows = 0;

    task automatic add_row(input logic s, input logic b, input logic [31:0] t,
                           input logic bw, input logic [31:0] rd,
                           input logic e_rd, input logic [31:0] e_addr,
                           input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic e_v);
        vecs[n_rows].stall     = s;
        vecs[n_rows].branch    = b;
        vecs[n_rows].target    = t;
        vecs[n_rows].busy      = bw;
        vecs[n_rows].rdata     = rd;
        vecs[n_rows].exp_read  = e_rd;
        vecs[n_rows].exp_addr  = e_addr;
        vecs[n_rows].exp_pc    = e_pc;
        vecs[n_rows].exp_instr = e_instr;
        vecs[n_rows].exp_valid = e_v;
        n_rows++;
    endtask

    // Each row: inputs during a cycle, outputs expected during that same cycle
    // (before the edge that ends it).
    task automatic fill_table();
        //       stall br  target         busy rdata           | read addr           ifid_pc        ifid_instr     valid
        // Zero-wait fetch after reset
        add_row(0, 0, 32'h0,   0, 32'h0,          0, 32'h0,   32'h0,   NOP,           0); // IDLE
        add_row(0, 0, 32'h0,   0, 32'h0050_0093,  1, 32'h0,   32'h0,   NOP,           0);
        add_row(0, 0, 32'h0,   0, 32'h00A0_0113,  1, 32'h4,   32'h0,   32'h0050_0093, 1);
        // Busywait 3 cycles at PC=8
        add_row(0, 0, 32'h0,   1, 32'h0,          1, 32'h8,   32'h4,   32'h00A0_0113, 1);
        add_row(0, 0, 32'h0,   1, 32'h0,          1, 32'h8,   32'h0,   NOP,           0);
        add_row(0, 0, 32'h0,   1, 32'h0,          1, 32'h8,   32'h0,   NOP,           0);
        add_row(0, 0, 32'h0,   0, 32'h0030_8193,  1, 32'h8,   32'h0,   NOP,           0);
        // Stall 2 cycles while PC=0xC completes
        add_row(1, 0, 32'h0,   0, 32'h0041_0213,  1, 32'hC,   32'h8,   32'h0030_8193, 1);
        add_row(1, 0, 32'h0,   0, 32'h0,          0, 32'h10,  32'h8,   32'h0030_8193, 1); // HOLD
        add_row(0, 0, 32'h0,   0, 32'h0,          0, 32'h10,  32'h8,   32'h0030_8193, 1); // HOLD release
        add_row(0, 0, 32'h0,   0, 32'h0052_0293,  1, 32'h10,  32'hC,   32'h0041_0213, 1);
        add_row(0, 0, 32'h0,   0, 32'h0060_0313,  1, 32'h14,  32'h10,  32'h0052_0293, 1);
        add_row(0, 0, 32'h0,   0, 32'h0070_0393,  1, 32'h18,  32'h14,  32'h0060_0313, 1);
        add_row(0, 0, 32'h0,   0, 32'h0080_0413,  1, 32'h1C,  32'h18,  32'h0070_0393, 1);
        // Branch to 0x103 while busy at PC=0x20 -> drain, then fetch 0x100
        add_row(0, 1, 32'h103, 1, 32'h0,          1, 32'h20,  32'h1C,  32'h0080_0413, 1);
        add_row(0, 0, 32'h0,   1, 32'h0,          1, 32'h20,  32'h0,   NOP,           0); // DRAIN
        add_row(0, 0, 32'h0,   0, 32'hDEAD_BEEF,  1, 32'h20,  32'h0,   NOP,           0); // DRAIN done
        add_row(0, 0, 32'h0,   0, 32'h0090_0493,  1, 32'h100, 32'h0,   NOP,           0);
        // Branch + stall on a completing fetch
        add_row(1, 1, 32'h200, 0, 32'hBAD0_0013,  1, 32'h104, 32'h100, 32'h0090_0493, 1);
        add_row(0, 0, 32'h0,   0, 32'h00A0_0513,  1, 32'h200, 32'h0,   NOP,           0);
        // Stall with an incomplete access keeps IF/ID
        add_row(1, 0, 32'h0,   1, 32'h0,          1, 32'h204, 32'h200, 32'h00A0_0513, 1);
        add_row(0, 0, 32'h0,   0, 32'h00B0_0593,  1, 32'h204, 32'h200, 32'h00A0_0513, 1);
        add_row(0, 0, 32'h0,   0, 32'h0,          1, 32'h208, 32'h204, 32'h00B0_0593, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n             = 1'b0;
        rst2_n            = 1'b0;
        stall             = 1'b0;
        branch_taken      = 1'b0;
        branch_target     = 32'd0;
        bus.IMEM_RDATA    = 32'd0;
        bus.IMEM_BUSYWAIT = 1'b0;
        bus2.IMEM_RDATA   = 32'd0;
        bus2.IMEM_BUSYWAIT = 1'b0;
        fill_table();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset read",  {31'd0, bus.IMEM_READ}, 32'd0);
        check("reset addr",  bus.IMEM_ADDR, 32'h0);
        check("reset pc",    bus.IFID_PC, 32'h0);
        check("reset instr", bus.IFID_INSTR, NOP);
        check("reset valid", {31'd0, bus.IFID_VALID}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);

        rst_n = 1'b1;
        for (int i = 0; i < n_rows; i++) begin
            stall             = vecs[i].stall;
            branch_taken      = vecs[i].branch;
            branch_target     = vecs[i].target;
            bus.IMEM_BUSYWAIT = vecs[i].busy;
            bus.IMEM_RDATA    = vecs[i].rdata;
            #1;
            check($sformatf("row%0d read", i),  {31'd0, bus.IMEM_READ},  {31'd0, vecs[i].exp_read});
            check($sformatf("row%0d addr", i),  bus.IMEM_ADDR,           vecs[i].exp_addr);
            check($sformatf("row%0d pc", i),    bus.IFID_PC,             vecs[i].exp_pc);
            check($sformatf("row%0d instr", i), bus.IFID_INSTR,          vecs[i].exp_instr);
            check($sformatf("row%0d valid", i), {31'd0, bus.IFID_VALID}, {31'd0, vecs[i].exp_valid});
            @(posedge clk);
            #1;
        end
        stall             = 1'b0;
        branch_taken      = 1'b0;
        bus.IMEM_BUSYWAIT = 1'b0;

        // PC wrap and reset during an outstanding access
        #1;
        check("wrap reset addr", bus2.IMEM_ADDR, 32'hFFFF_FFFC);
        check("wrap reset read", {31'd0, bus2.IMEM_READ}, 32'd0);
        rst2_n          = 1'b1;
        bus2.IMEM_RDATA = 32'h00C0_0613;
        @(posedge clk); #1;   // now FETCH
        check("wrap fetch read", {31'd0, bus2.IMEM_READ}, 32'd1);
        check("wrap fetch addr", bus2.IMEM_ADDR, 32'hFFFF_FFFC);
        @(posedge clk); #1;   // fetch done, PC wrapped
        check("wrap next addr",  bus2.IMEM_ADDR, 32'h0);
        check("wrap ifid pc",    bus2.IFID_PC, 32'hFFFF_FFFC);
        check("wrap ifid instr", bus2.IFID_INSTR, 32'h00C0_0613);
        check("wrap ifid valid", {31'd0, bus2.IFID_VALID}, 32'd1);
        bus2.IMEM_BUSYWAIT = 1'b1;
        @(posedge clk); #1;
        check("wrap busy addr",  bus2.IMEM_ADDR, 32'h0);
        check("wrap busy valid", {31'd0, bus2.IFID_VALID}, 32'd0);
        rst2_n = 1'b0;        // reset while the access is outstanding
        @(posedge clk); #1;
        check("midrst read",  {31'd0, bus2.IMEM_READ}, 32'd0);
        check("midrst addr",  bus2.IMEM_ADDR, 32'hFFFF_FFFC);
        check("midrst pc",    bus2.IFID_PC, 32'h0);
        check("midrst instr", bus2.IFID_INSTR, NOP);
        check("midrst valid", {31'd0, bus2.IFID_VALID}, 32'd0);
        check("midrst state", {30'd0, dbg_state2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
